// File: rtl/pipe_control_unit_pkg.sv
// Shared encodings and the control bundle for the pipelined MIPS control unit.
package pipe_control_unit_pkg;

    // Primary opcodes recognised by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct field values
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // Base ALU operation codes; wider AluControl buses zero-extend these
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Width of the MDU busy counter, enough for latencies up to 15
    localparam int MDU_CNT_W = 4;

    // Single-bit controls produced by the ID-stage decoder.
    // mduOrMove marks instructions that touch HI/LO and so must wait for the MDU.
    typedef struct packed {
        logic regWrite;
        logic regDst;
        logic aluSrc;
        logic memtoReg;
        logic memWrite;
        logic branch;
        logic jump;
        logic mduStart;
        logic mduOrMove;
        logic illegal;
    } ctrl_t;

    // True for the four multiply/divide functs
    function automatic logic isMduFunct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/pipe_ctrl_decoder.sv
// Combinational op/funct decoder producing the control bundle for the ID stage.
// Anything not recognised comes out as illegal with every write enable low.
module pipe_ctrl_decoder
    import pipe_control_unit_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit EN_MDU    = 1'b1
) (
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    output ctrl_t                ctrl,
    output logic [ALUCTRL_W-1:0] aluControl
);

    logic [2:0] aluCode;

    // Decode the instruction; defaults describe an all-quiet bubble
    always_comb begin
        ctrl    = '0;
        aluCode = ALU_AND;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD: begin
                        ctrl.regWrite = 1'b1;
                        ctrl.regDst   = 1'b1;
                        aluCode       = ALU_ADD;
                    end
                    F_SUB: begin
                        ctrl.regWrite = 1'b1;
                        ctrl.regDst   = 1'b1;
                        aluCode       = ALU_SUB;
                    end
                    F_AND: begin
                        ctrl.regWrite = 1'b1;
                        ctrl.regDst   = 1'b1;
                        aluCode       = ALU_AND;
                    end
                    F_OR: begin
                        ctrl.regWrite = 1'b1;
                        ctrl.regDst   = 1'b1;
                        aluCode       = ALU_OR;
                    end
                    F_SLT: begin
                        ctrl.regWrite = 1'b1;
                        ctrl.regDst   = 1'b1;
                        aluCode       = ALU_SLT;
                    end
                    F_MFHI, F_MFLO: begin
                        ctrl.regWrite  = 1'b1;
                        ctrl.regDst    = 1'b1;
                        ctrl.mduOrMove = 1'b1;
                        aluCode        = ALU_ADD;
                    end
                    default: begin
                        if (EN_MDU && isMduFunct(funct)) begin
                            ctrl.mduStart  = 1'b1;
                            ctrl.mduOrMove = 1'b1;
                        end else begin
                            ctrl.illegal = 1'b1;
                        end
                    end
                endcase
            end
            OP_LW: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.memtoReg = 1'b1;
                aluCode       = ALU_ADD;
            end
            OP_SW: begin
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                aluCode       = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                aluCode     = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                aluCode       = ALU_ADD;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

    // Zero-extend the base code so a 4-bit bus carries a 0 MSB
    assign aluControl = ALUCTRL_W'(aluCode);

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control unit: decodes in ID and carries the controls through
// ID/EX, EX/MEM and MEM/WB, inserting bubbles for stalls, flushes and MDU waits.
// ALUCTRL_W must be 3 or 4; MDU_LAT must lie in 1..15.
module pipe_control_unit
    import pipe_control_unit_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int MDU_LAT   = 4,
    parameter bit EN_MDU    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 id_valid,
    input  logic                 stall_id,
    input  logic                 flush_ex,
    output logic                 id_jump,
    output logic                 stall_req,
    output logic                 ex_RegDst,
    output logic                 ex_AluSrc,
    output logic [ALUCTRL_W-1:0] ex_AluControl,
    output logic                 ex_mdu_start,
    output logic                 mem_MemWrite,
    output logic                 mem_Branch,
    output logic                 wb_RegWrite,
    output logic                 wb_MemtoReg,
    output logic                 illegal,
    output logic                 mdu_busy
);

    ctrl_t                idCtrl;
    logic [ALUCTRL_W-1:0] idAluControl;
    logic                 idBubble;
    logic                 mduBusy;

    // Controls that ride through EX and MEM without being exposed there
    logic exRegWrite;
    logic exMemtoReg;
    logic exMemWrite;
    logic exBranch;
    logic memRegWrite;
    logic memMemtoReg;

    pipe_ctrl_decoder #(
        .ALUCTRL_W (ALUCTRL_W),
        .EN_MDU    (EN_MDU)
    ) decoder (
        .op         (op),
        .funct      (funct),
        .ctrl       (idCtrl),
        .aluControl (idAluControl)
    );

    // Jump steers the ID-stage PC mux directly and ignores stalls
    assign id_jump = id_valid & idCtrl.jump;

    // HI/LO users in ID must wait while the MDU is still computing
    assign stall_req = mduBusy & id_valid & idCtrl.mduOrMove;
    assign mdu_busy  = mduBusy;

    // Any reason not to let the ID instruction advance turns it into a bubble
    assign idBubble = !id_valid || stall_id || stall_req || flush_ex;

    // ID/EX register: load decoded controls or an all-zero bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_RegDst     <= 1'b0;
            ex_AluSrc     <= 1'b0;
            ex_AluControl <= '0;
            ex_mdu_start  <= 1'b0;
            illegal       <= 1'b0;
            exRegWrite    <= 1'b0;
            exMemtoReg    <= 1'b0;
            exMemWrite    <= 1'b0;
            exBranch      <= 1'b0;
        end else if (idBubble) begin
            ex_RegDst     <= 1'b0;
            ex_AluSrc     <= 1'b0;
            ex_AluControl <= '0;
            ex_mdu_start  <= 1'b0;
            illegal       <= 1'b0;
            exRegWrite    <= 1'b0;
            exMemtoReg    <= 1'b0;
            exMemWrite    <= 1'b0;
            exBranch      <= 1'b0;
        end else begin
            ex_RegDst     <= idCtrl.regDst;
            ex_AluSrc     <= idCtrl.aluSrc;
            ex_AluControl <= idAluControl;
            ex_mdu_start  <= idCtrl.mduStart;
            illegal       <= idCtrl.illegal;
            exRegWrite    <= idCtrl.regWrite;
            exMemtoReg    <= idCtrl.memtoReg;
            exMemWrite    <= idCtrl.memWrite;
            exBranch      <= idCtrl.branch;
        end
    end

    // EX/MEM register: always advances, bubbles included
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_MemWrite <= 1'b0;
            mem_Branch   <= 1'b0;
            memRegWrite  <= 1'b0;
            memMemtoReg  <= 1'b0;
        end else begin
            mem_MemWrite <= exMemWrite;
            mem_Branch   <= exBranch;
            memRegWrite  <= exRegWrite;
            memMemtoReg  <= exMemtoReg;
        end
    end

    // MEM/WB register: always advances
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_RegWrite <= 1'b0;
            wb_MemtoReg <= 1'b0;
        end else begin
            wb_RegWrite <= memRegWrite;
            wb_MemtoReg <= memMemtoReg;
        end
    end

    generate
        if (EN_MDU) begin : gMdu
            logic [MDU_CNT_W-1:0] mduCount;

            // Busy counter: reload as an MDU op enters EX, then count down to idle
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mduCount <= '0;
                end else if (!idBubble && idCtrl.mduStart) begin
                    mduCount <= MDU_CNT_W'(MDU_LAT);
                end else if (mduCount != '0) begin
                    mduCount <= mduCount - 1'b1;
                end
            end

            assign mduBusy = (mduCount != '0);
        end else begin : gNoMdu
            assign mduBusy = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed testbench for pipe_control_unit with hand-computed expectations.
module tb_pipe_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       id_valid;
    logic       stall_id;
    logic       flush_ex;
    logic       id_jump;
    logic       stall_req;
    logic       ex_RegDst;
    logic       ex_AluSrc;
    logic [2:0] ex_AluControl;
    logic       ex_mdu_start;
    logic       mem_MemWrite;
    logic       mem_Branch;
    logic       wb_RegWrite;
    logic       wb_MemtoReg;
    logic       illegal;
    logic       mdu_busy;

    int checks = 0;
    int errors = 0;

    // Every output packed together so "all zero" is a single compare
    logic [13:0] allOut;
    assign allOut = {id_jump, stall_req, ex_RegDst, ex_AluSrc, ex_AluControl,
                     ex_mdu_start, mem_MemWrite, mem_Branch, wb_RegWrite,
                     wb_MemtoReg, illegal, mdu_busy};

    // EX-stage controls packed together for bubble checks
    logic [6:0] exOut;
    assign exOut = {ex_RegDst, ex_AluSrc, ex_AluControl, ex_mdu_start, illegal};

    pipe_control_unit #(
        .ALUCTRL_W (3),
        .MDU_LAT   (4),
        .EN_MDU    (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct         (funct),
        .id_valid      (id_valid),
        .stall_id      (stall_id),
        .flush_ex      (flush_ex),
        .id_jump       (id_jump),
        .stall_req     (stall_req),
        .ex_RegDst     (ex_RegDst),
        .ex_AluSrc     (ex_AluSrc),
        .ex_AluControl (ex_AluControl),
        .ex_mdu_start  (ex_mdu_start),
        .mem_MemWrite  (mem_MemWrite),
        .mem_Branch    (mem_Branch),
        .wb_RegWrite   (wb_RegWrite),
        .wb_MemtoReg   (wb_MemtoReg),
        .illegal       (illegal),
        .mdu_busy      (mdu_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                                 input logic v, input logic s, input logic fl);
        op       = o;
        funct    = f;
        id_valid = v;
        stall_id = s;
        flush_ex = fl;
    endtask

    task automatic idle();
        applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        checks++;
        if (allOut !== 14'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: actual=%b required=%b", allOut, 14'b0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (allOut !== 14'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: actual=%b required=%b", allOut, 14'b0);
        end
    endtask

    task automatic test_reset_midstream();
        applyStimulus(6'b100011, 6'b000000, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if (ex_AluSrc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_lw_in_ex: actual=%b required=1", ex_AluSrc);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (allOut !== 14'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async: actual=%b required=%b", allOut, 14'b0);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (allOut !== 14'b0) begin
                errors++;
                $display("[TB] FAIL midreset_after_%0d: actual=%b required=%b", k, allOut, 14'b0);
            end
        end
    endtask

    task automatic test_lw_latency();
        applyStimulus(6'b100011, 6'b000000, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if ({ex_AluSrc, ex_AluControl, ex_RegDst} !== 5'b1_010_0) begin
            errors++;
            $display("[TB] FAIL lw_ex: actual=%b required=%b",
                     {ex_AluSrc, ex_AluControl, ex_RegDst}, 5'b1_010_0);
        end
        tick();
        checks++;
        if (mem_MemWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_mem: actual=%b required=0", mem_MemWrite);
        end
        tick();
        checks++;
        if ({wb_RegWrite, wb_MemtoReg} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL lw_wb: actual=%b required=11", {wb_RegWrite, wb_MemtoReg});
        end
    endtask

    task automatic test_rtype_alu();
        logic [5:0] functs [5];
        logic [2:0] codes  [5];
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        codes  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(6'b000000, functs[i], 1'b1, 1'b0, 1'b0);
            tick();
            checks++;
            if ({ex_RegDst, ex_AluControl, illegal} !== {1'b1, codes[i], 1'b0}) begin
                errors++;
                $display("[TB] FAIL rtype_%0d: actual=%b required=%b", i,
                         {ex_RegDst, ex_AluControl, illegal}, {1'b1, codes[i], 1'b0});
            end
        end
        idle();
        tick();
        tick();
        checks++;
        if (wb_RegWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rtype_wb: actual=%b required=1", wb_RegWrite);
        end
        tick();
        tick();
    endtask

    task automatic test_stall_flush();
        applyStimulus(6'b101011, 6'b000000, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (exOut !== 7'b0) begin
            errors++;
            $display("[TB] FAIL sw_stall_bubble: actual=%b required=%b", exOut, 7'b0);
        end
        applyStimulus(6'b101011, 6'b000000, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if ({ex_AluSrc, ex_AluControl} !== 4'b1_010) begin
            errors++;
            $display("[TB] FAIL sw_ex: actual=%b required=1010", {ex_AluSrc, ex_AluControl});
        end
        tick();
        checks++;
        if (mem_MemWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sw_mem: actual=%b required=1", mem_MemWrite);
        end
        // beq squashed by flush, then by flush together with stall
        applyStimulus(6'b000100, 6'b000000, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (exOut !== 7'b0) begin
            errors++;
            $display("[TB] FAIL beq_flush_bubble: actual=%b required=%b", exOut, 7'b0);
        end
        applyStimulus(6'b000100, 6'b000000, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if (exOut !== 7'b0) begin
            errors++;
            $display("[TB] FAIL beq_flush_stall_bubble: actual=%b required=%b", exOut, 7'b0);
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (mem_Branch !== 1'b0) begin
                errors++;
                $display("[TB] FAIL beq_flush_mem_%0d: actual=%b required=0", k, mem_Branch);
            end
        end
        // Unflushed beq must reach MEM with Branch set
        applyStimulus(6'b000100, 6'b000000, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if (ex_AluControl !== 3'b110) begin
            errors++;
            $display("[TB] FAIL beq_ex: actual=%b required=110", ex_AluControl);
        end
        tick();
        checks++;
        if (mem_Branch !== 1'b1) begin
            errors++;
            $display("[TB] FAIL beq_mem: actual=%b required=1", mem_Branch);
        end
        tick();
        tick();
    endtask

    task automatic test_mdu_stall();
        int n;
        applyStimulus(6'b000000, 6'b011000, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if ({stall_req, mdu_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mult_id_nostall: actual=%b required=00", {stall_req, mdu_busy});
        end
        tick();
        applyStimulus(6'b000000, 6'b010010, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if ({ex_mdu_start, mdu_busy, stall_req, ex_RegDst} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL mult_ex: actual=%b required=1110",
                     {ex_mdu_start, mdu_busy, stall_req, ex_RegDst});
        end
        n = 0;
        for (int k = 0; k < 20 && stall_req === 1'b1; k++) begin
            n++;
            tick();
            checks++;
            if (exOut !== 7'b0) begin
                errors++;
                $display("[TB] FAIL mdu_stall_bubble_%0d: actual=%b required=%b", k, exOut, 7'b0);
            end
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("[TB] FAIL mdu_stall_length: actual=%0d required=4", n);
        end
        checks++;
        if (mdu_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mdu_idle: actual=%b required=0", mdu_busy);
        end
        tick();
        idle();
        checks++;
        if ({ex_RegDst, ex_AluControl, ex_mdu_start} !== 5'b1_010_0) begin
            errors++;
            $display("[TB] FAIL mflo_ex: actual=%b required=10100",
                     {ex_RegDst, ex_AluControl, ex_mdu_start});
        end
        tick();
        tick();
        checks++;
        if ({wb_RegWrite, wb_MemtoReg} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL mflo_wb: actual=%b required=10", {wb_RegWrite, wb_MemtoReg});
        end
        tick();
    endtask

    task automatic test_illegal_jump();
        applyStimulus(6'b111111, 6'b000000, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(6'b000000, 6'b000001, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({illegal, ex_RegDst, ex_AluSrc} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL illegal_op_ex: actual=%b required=100", {illegal, ex_RegDst, ex_AluSrc});
        end
        tick();
        idle();
        checks++;
        if ({illegal, ex_RegDst} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL illegal_funct_ex: actual=%b required=10", {illegal, ex_RegDst});
        end
        tick();
        checks++;
        if ({illegal, mem_MemWrite} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL illegal_clears: actual=%b required=00", {illegal, mem_MemWrite});
        end
        checks++;
        if (wb_RegWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_wb: actual=%b required=0", wb_RegWrite);
        end
        tick();
        // Jump is combinational and ignores the stall
        applyStimulus(6'b000010, 6'b000000, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (id_jump !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jump_stalled: actual=%b required=1", id_jump);
        end
        applyStimulus(6'b000010, 6'b000000, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (id_jump !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jump_invalid: actual=%b required=0", id_jump);
        end
        applyStimulus(6'b000010, 6'b000000, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (id_jump !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jump_id: actual=%b required=1", id_jump);
        end
        tick();
        idle();
        checks++;
        if (exOut !== 7'b0) begin
            errors++;
            $display("[TB] FAIL jump_ex: actual=%b required=%b", exOut, 7'b0);
        end
        tick();
        checks++;
        if (mem_MemWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jump_mem: actual=%b required=0", mem_MemWrite);
        end
        tick();
        checks++;
        if (wb_RegWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jump_wb: actual=%b required=0", wb_RegWrite);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_reset_midstream();
        test_lw_latency();
        test_rtype_alu();
        test_stall_flush();
        test_mdu_stall();
        test_illegal_jump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Pipelined successor to the combinational MIPS control decoder in the 5-stage pipeline.
- Decodes op/funct in ID and carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages.
- Applies stall and flush bubbles, and runs a mult/div busy counter that raises a stall request.
- Sits between the instruction register and the datapath; the hazard unit drives stall_id and flush_ex.

Parameters:
- ALUCTRL_W, 3, width of AluControl. Legal values are 3 or 4; when 4, the MSB is 0 for all base ops.
- MDU_LAT, 4, cycles a mult/multu/div/divu keeps the MDU busy. Range 1..15.
- EN_MDU, 1, when 0, MDU functs decode as illegal and the counter is removed.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all pipeline registers and the MDU counter
- op  in  6  ID-stage opcode
- funct  in  6  ID-stage funct
- id_valid  in  1  ID holds a real instruction
- stall_id  in  1  hazard unit load-use stall
- flush_ex  in  1  branch/jump redirect; squashes the ID instruction
- id_jump  out  1  combinational Jump for the ID-stage PC mux
- stall_req  out  1  MDU-induced stall request to the hazard unit/PC
- ex_RegDst, ex_AluSrc  out  1 each  EX-stage controls
- ex_AluControl  out  ALUCTRL_W  EX-stage ALU operation
- ex_mdu_start  out  1  EX holds an MDU op
- mem_MemWrite, mem_Branch  out  1 each  MEM-stage controls
- wb_RegWrite, wb_MemtoReg  out  1 each  WB-stage controls
- illegal  out  1  registered in EX: EX holds a valid undecodable instruction
- mdu_busy  out  1  MDU counter nonzero

Behaviour:
- Reset: every registered output is 0, the MDU counter is 0, and stall_req is 0.
- Decode, with op in binary:
  - 000000 R-type: RegWrite, RegDst.
  - 100011 lw: RegWrite, AluSrc, MemtoReg, add.
  - 101011 sw: MemWrite, AluSrc, add.
  - 000100 beq: Branch, sub.
  - 001000 addi: RegWrite, AluSrc, add.
  - 000010 j: Jump only.
- R-type funct encodings:
  - 100000 add = 010; 100010 sub = 110; 100100 and = 000; 100101 or = 001; 101010 slt = 111.
  - 011000/011001/011010/011011 MDU: no RegWrite, ex_mdu_start=1.
  - 010000 mfhi and 010010 mflo: RegWrite, RegDst, AluControl 010.
- Any other op/funct: illegal=1 and all write enables are 0.
- id_jump = id_valid & (op==000010), combinational, and not gated by stall.
- Pipeline latency: ID decode appears on ex_* one cycle later, mem_* two cycles later, wb_* three cycles later.
- Bubble: ID/EX loads all-zero control when any of the following holds:
  - !id_valid
  - stall_id
  - stall_req
  - flush_ex
- EX/MEM and MEM/WB always advance; bubbles never stop downstream stages.
- flush_ex and stall_id in the same cycle: bubble (identical result).
- MDU counter:
  - Loads MDU_LAT when an MDU op enters EX.
  - Decrements each cycle while nonzero.
  - mdu_busy = (count != 0).
- stall_req = mdu_busy & id_valid & ID is an MDU op, mfhi or mflo.
  - It holds until the cycle the count is 0; that instruction then enters EX.
- A new MDU op entering EX while busy cannot occur, because stall_req blocks it. If forced, the counter reloads.
- Reset mid-operation: asynchronous clear, and the in-flight MDU count is abandoned.

Decomposition:
- Shared package/header holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO.
  - ALU control codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
- One sub-module, pipe_ctrl_decoder: combinational op/funct to control bundle plus illegal.
- The top level holds the stage registers and the MDU counter.

Test Plan:
- Reset mid-stream:
  - Stimulus: issue lw, then assert reset for 1 cycle while it sits in EX.
  - Response: all outputs read 0 immediately and remain 0 after release.
- lw latency:
  - Stimulus: lw (op 100011) with id_valid=1 at cycle 0.
  - Response: ex_AluSrc=1 and ex_AluControl=010 at cycle 1; mem_MemWrite=0 at cycle 2; wb_RegWrite=1 and wb_MemtoReg=1 at cycle 3.
- R-type ALU codes:
  - Stimulus: stream add, sub, and, or, slt back-to-back.
  - Response: ex_AluControl sequence 010, 110, 000, 001, 111, with ex_RegDst=1 throughout.
- Stall and flush bubbles:
  - Stimulus: sw with stall_id=1 on cycle 0 only.
  - Response: all ex_* are 0 at cycle 1. Re-present sw and mem_MemWrite=1 two cycles later.
  - Stimulus: flush_ex with beq in ID.
  - Response: mem_Branch is never 1.
- MDU stall, MDU_LAT=4:
  - Stimulus: mult, then mflo immediately after.
  - Response: ex_mdu_start=1, then stall_req=1 for exactly 4 cycles while ex_* are bubbles. After that, mflo reaches wb_RegWrite=1.
- Illegal and jump:
  - Stimulus: op 111111.
  - Response: illegal=1 in EX and wb_RegWrite=0.
  - Stimulus: op 000010.
  - Response: id_jump=1 in the same cycle, with no downstream writes.
